// File: rtl/serial_byte_sender_if.sv
// Handshake/data bundle between the byte source and serial_byte_sender.
// The sender is the slave: it receives start/din and drives the serial outputs.
interface serial_byte_sender_if;
    logic       start;
    logic [7:0] din;
    logic       sdo;
    logic       strobe;
    logic       busy;
    logic       done;

    modport master (
        output start, din,
        input  sdo, strobe, busy, done
    );

    modport slave (
        input  start, din,
        output sdo, strobe, busy, done
    );
endinterface

// File: rtl/serial_byte_sender.sv
// MSB-first parallel-to-serial sender with prescaler clock enable and per-bit strobe.
// Define SERIAL_SENDER_PARITY_EN to append an even-parity bit after din[0].
module serial_byte_sender #(
    parameter int unsigned DIV   = 25000000,
    parameter int unsigned CNT_W = 25
) (
    input  logic                 clk,
    input  logic                 clr,
    serial_byte_sender_if.slave  bus
);
`ifdef SERIAL_SENDER_PARITY_EN
    localparam int unsigned SH_W = 9;
`else
    localparam int unsigned SH_W = 8;
`endif
    localparam logic [3:0]       LAST = 4'(SH_W - 1);
    localparam logic [CNT_W-1:0] TOP  = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]  presc_q, presc_d;
    logic              sdo_q, sdo_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SH_W-1:0]   load_val;

`ifdef SERIAL_SENDER_PARITY_EN
    assign load_val = {bus.din, ^bus.din};
`else
    assign load_val = bus.din;
`endif

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bitcnt_d = bitcnt_q;
        presc_d  = presc_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SHIFT;
                    sh_d     = load_val;
                    bitcnt_d = '0;
                    presc_d  = '0;
                end
            end
            SHIFT: begin
                if (presc_q == TOP) begin
                    presc_d = '0;
                    if (bitcnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        sh_d     = {sh_q[SH_W-2:0], 1'b0};
                    end
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so derive them from the next state so they
        // line up with the state they describe.
        busy_d   = (state_d == SHIFT);
        done_d   = (state_d == DONE);
        sdo_d    = busy_d & sh_d[SH_W-1];
        strobe_d = busy_d && (presc_d == TOP);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            bitcnt_q <= '0;
            presc_q  <= '0;
            sdo_q    <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            bitcnt_q <= bitcnt_d;
            presc_q  <= presc_d;
            sdo_q    <= sdo_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.sdo    = sdo_q;
    assign bus.strobe = strobe_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_serial_byte_sender.sv
// Bench for serial_byte_sender: three instances (DIV = 4, 1, 2) share one stimulus
// stream and are checked every cycle against a frame-timing reference model.
module tb_serial_byte_sender;
`ifdef SERIAL_SENDER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [7:0] din;

    always #5 clk = ~clk;

    serial_byte_sender_if bus0 ();
    serial_byte_sender_if bus1 ();
    serial_byte_sender_if bus2 ();

    assign bus0.start = start;  assign bus0.din = din;
    assign bus1.start = start;  assign bus1.din = din;
    assign bus2.start = start;  assign bus2.din = din;

    serial_byte_sender #(.DIV(4), .CNT_W(3)) u_div4 (.clk(clk), .clr(clr), .bus(bus0));
    serial_byte_sender #(.DIV(1), .CNT_W(1)) u_div1 (.clk(clk), .clr(clr), .bus(bus1));
    serial_byte_sender #(.DIV(2), .CNT_W(2)) u_div2 (.clk(clk), .clr(clr), .bus(bus2));

    logic sdo_w [3];
    logic stb_w [3];
    logic bsy_w [3];
    logic dne_w [3];
    assign sdo_w[0] = bus0.sdo;  assign stb_w[0] = bus0.strobe;
    assign bsy_w[0] = bus0.busy; assign dne_w[0] = bus0.done;
    assign sdo_w[1] = bus1.sdo;  assign stb_w[1] = bus1.strobe;
    assign bsy_w[1] = bus1.busy; assign dne_w[1] = bus1.done;
    assign sdo_w[2] = bus2.sdo;  assign stb_w[2] = bus2.strobe;
    assign bsy_w[2] = bus2.busy; assign dne_w[2] = bus2.done;

    // Reference model: t = cycles since the accepting edge (0 = idle).
    // Cycles 1..NB*DIV carry bits, cycle NB*DIV+1 is the done cycle.
    int         divs [3] = '{4, 1, 2};
    int         t    [3] = '{0, 0, 0};
    logic [7:0] cap  [3];

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j < 8) return b[7 - j];
        return ^b;
    endfunction

    task automatic chk(input string tag, input int i, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s inst%0d(DIV=%0d) cycle %0d observed=%b expected=%b",
                    tag, i, divs[i], cyc, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            int len;
            len = NB * divs[i];
            if (clr)              t[i] = 0;
            else if (t[i] == 0) begin
                if (start) begin
                    t[i]   = 1;
                    cap[i] = din;
                end
            end
            else if (t[i] <= len) t[i] = t[i] + 1;
            else                  t[i] = 0;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            int   len;
            logic shifting;
            len      = NB * divs[i];
            shifting = (t[i] >= 1) && (t[i] <= len);
            chk("busy",   i, bsy_w[i], shifting);
            chk("done",   i, dne_w[i], t[i] == len + 1);
            chk("strobe", i, stb_w[i], shifting && (t[i] % divs[i] == 0));
            chk("sdo",    i, sdo_w[i], shifting ? frame_bit(cap[i], (t[i] - 1) / divs[i]) : 1'b0);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse(input logic [7:0] b);
        din   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        @(negedge clk);
        run(2);
        clr = 1'b0;
        run(2);

        // basic frame A5
        pulse(8'hA5);
        run(45);

        // start pulse mid-frame with new data is ignored
        pulse(8'hA5);
        run(3);
        pulse(8'hFF);
        din = 8'h00;
        run(45);

        // DIV=1 style pattern
        pulse(8'h81);
        run(45);

        // reset mid-frame, then a clean frame
        pulse(8'hA5);
        run(9);
        clr = 1'b1;
        run(2);
        clr = 1'b0;
        run(8);
        pulse(8'h5A);
        run(45);

        // start held high: back-to-back frames
        din   = 8'h3C;
        start = 1'b1;
        run(110);
        start = 1'b0;
        run(45);

        // parity-relevant bytes (odd and even popcount)
        pulse(8'h07);
        run(45);
        pulse(8'h03);
        run(45);

        // random starts, data churn and occasional resets
        for (int n = 0; n < 500; n++) begin
            start = ($urandom_range(0, 3) == 0);
            din   = 8'($urandom);
            clr   = ($urandom_range(0, 70) == 0);
            tick();
        end
        clr   = 1'b0;
        start = 1'b0;
        run(45);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
